// File: rtl/game_state_tracker.sv
// ============================================================================
// game_state_tracker
// ----------------------------------------------------------------------------
// Purpose:
//   Owns the round state of a tank match (IDLE, PLAY, WIN, LOSE and an
//   optional DRAW) and tracks both sides' hit points. Hits are collected
//   during a frame and applied only on the frame tick (rising edge of
//   vblnk_in), so HP and game_end never change mid-frame.
//
// Ports:
//   clk           in   pixel clock
//   rst           in   asynchronous reset, active-high
//   vblnk_in      in   vertical blank; its rising edge is the frame tick
//   start         in   one-cycle pulse from the menu, begins a match
//   back_to_MENU  in   one-cycle pulse from the end screen, leaves WIN/LOSE
//   player_hit    in   one-cycle pulse, a projectile hit the player tank
//   enemy_hit     in   one-cycle pulse, a projectile hit the enemy tank
//   game_end      out  0 none, 1 win, 2 lose, 3 draw (draw build only)
//   game_active   out  high while in PLAY
//   player_hp     out  current player HP
//   enemy_hp      out  current enemy HP
//
// Parameters:
//   PLAYER_HP     starting player HP (1..15)
//   ENEMY_HP      starting enemy HP (1..15)
//   HIT_COOLDOWN  frames of invulnerability after an applied hit (0..255)
//
// Build option:
//   GAME_STATE_TIE_EN  when defined, both sides reaching zero on the same
//                      tick ends in DRAW (game_end = 3); otherwise the
//                      player loses.
// ============================================================================
module game_state_tracker #(
   parameter int PLAYER_HP    = 3,
   parameter int ENEMY_HP     = 3,
   parameter int HIT_COOLDOWN = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vblnk_in,
   input  logic       start,
   input  logic       back_to_MENU,
   input  logic       player_hit,
   input  logic       enemy_hit,
   output logic [1:0] game_end,
   output logic       game_active,
   output logic [3:0] player_hp,
   output logic [3:0] enemy_hp
);

   // -------------------------------------------------------------------------
   // State encoding
   // -------------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PLAY = 3'd1;
   localparam logic [2:0] ST_WIN  = 3'd2;
   localparam logic [2:0] ST_LOSE = 3'd3;
`ifdef GAME_STATE_TIE_EN
   localparam logic [2:0] ST_DRAW = 3'd4;
`endif

   localparam logic [1:0] END_NONE = 2'd0;
   localparam logic [1:0] END_WIN  = 2'd1;
   localparam logic [1:0] END_LOSE = 2'd2;
`ifdef GAME_STATE_TIE_EN
   localparam logic [1:0] END_DRAW = 2'd3;
`endif

   localparam logic [7:0] COOLDOWN_LOAD = 8'(HIT_COOLDOWN);
   localparam logic [3:0] PLAYER_INIT   = 4'(PLAYER_HP);
   localparam logic [3:0] ENEMY_INIT    = 4'(ENEMY_HP);

   // Side index 0 is the player, side index 1 is the enemy.
   localparam int SIDES = 2;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   logic [2:0]             state_q,       state_d;
   logic                   vblnk_q;
   logic [SIDES-1:0][3:0]  hp_q,          hp_d;
   logic [SIDES-1:0][7:0]  cd_q,          cd_d;
   logic [SIDES-1:0]       pend_q,        pend_d;
   logic [1:0]             game_end_q,    game_end_d;
   logic                   game_active_q, game_active_d;

   // -------------------------------------------------------------------------
   // Frame tick: first cycle of vblank
   // -------------------------------------------------------------------------
   logic frame_tick;
   assign frame_tick = vblnk_in & ~vblnk_q;

   logic [SIDES-1:0] hit_in;
   assign hit_in = {enemy_hit, player_hit};

   // -------------------------------------------------------------------------
   // Per-side tick result: what HP and cooldown become if this cycle is a
   // frame tick in PLAY. A hit arriving in the tick cycle itself is folded
   // into the pending flag so it counts toward this tick.
   // -------------------------------------------------------------------------
   logic [SIDES-1:0]       pend_eff;
   logic [SIDES-1:0]       apply_hit;
   logic [SIDES-1:0][3:0]  hp_dec;
   logic [SIDES-1:0][3:0]  hp_tick;
   logic [SIDES-1:0][7:0]  cd_tick;

   genvar gi;
   generate
      for (gi = 0; gi < SIDES; gi++) begin : g_side
         assign pend_eff[gi]  = pend_q[gi] | hit_in[gi];
         assign apply_hit[gi] = (cd_q[gi] == 8'd0) && pend_eff[gi];
         assign hp_dec[gi]    = (hp_q[gi] == 4'd0) ? 4'd0 : (hp_q[gi] - 4'd1);
         assign hp_tick[gi]   = apply_hit[gi] ? hp_dec[gi] : hp_q[gi];
         // While cooling down the counter runs and any pending hit is lost.
         assign cd_tick[gi]   = apply_hit[gi]        ? COOLDOWN_LOAD :
                                (cd_q[gi] != 8'd0)   ? (cd_q[gi] - 8'd1) :
                                                       cd_q[gi];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      hp_d    = hp_q;
      cd_d    = cd_q;
      pend_d  = pend_q;

      case (state_q)
         ST_IDLE: begin
            // Hits and back_to_MENU have no meaning before a match.
            pend_d = '0;
            if (start) begin
               state_d  = ST_PLAY;
               hp_d[0]  = PLAYER_INIT;
               hp_d[1]  = ENEMY_INIT;
               cd_d     = '0;
            end
         end

         ST_PLAY: begin
            if (frame_tick) begin
               hp_d   = hp_tick;
               cd_d   = cd_tick;
               pend_d = '0;
               // Outcome is judged on the post-update HP; the player side
               // is checked first so a simultaneous zero never reads as a win.
               if (hp_tick[0] == 4'd0) begin
`ifdef GAME_STATE_TIE_EN
                  state_d = (hp_tick[1] == 4'd0) ? ST_DRAW : ST_LOSE;
`else
                  state_d = ST_LOSE;
`endif
               end else if (hp_tick[1] == 4'd0) begin
                  state_d = ST_WIN;
               end
            end else begin
               // Sticky until the tick; repeated hits collapse to one.
               pend_d = pend_q | hit_in;
            end
         end

         ST_WIN,
`ifdef GAME_STATE_TIE_EN
         ST_DRAW,
`endif
         ST_LOSE: begin
            // End screen: everything frozen until the overlay hands back.
            pend_d = '0;
            if (back_to_MENU) begin
               state_d = ST_IDLE;
               hp_d    = '0;
            end
         end

         default: begin
            // Unreachable encodings recover to a clean idle.
            state_d = ST_IDLE;
            hp_d    = '0;
            cd_d    = '0;
            pend_d  = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output decode from the next state, so the registered outputs change on
   // the same edge as the state itself.
   // -------------------------------------------------------------------------
   always_comb begin
      game_end_d    = END_NONE;
      game_active_d = (state_d == ST_PLAY);
      case (state_d)
         ST_WIN:  game_end_d = END_WIN;
         ST_LOSE: game_end_d = END_LOSE;
`ifdef GAME_STATE_TIE_EN
         ST_DRAW: game_end_d = END_DRAW;
`endif
         default: game_end_d = END_NONE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         vblnk_q       <= 1'b0;
         hp_q          <= '0;
         cd_q          <= '0;
         pend_q        <= '0;
         game_end_q    <= END_NONE;
         game_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         vblnk_q       <= vblnk_in;
         hp_q          <= hp_d;
         cd_q          <= cd_d;
         pend_q        <= pend_d;
         game_end_q    <= game_end_d;
         game_active_q <= game_active_d;
      end
   end

   assign game_end    = game_end_q;
   assign game_active = game_active_q;
   assign player_hp   = hp_q[0];
   assign enemy_hp    = hp_q[1];

endmodule

// File: tb/tb_game_state_tracker.sv
// ============================================================================
// tb_game_state_tracker
// Two instances share one stimulus stream: u_dut0 with no hit cooldown and
// u_dut2 with a two-frame cooldown. A frame-level reference model tracks
// each instance; directed table rows and hand-written sequences add fixed
// expectations for the corner cases, followed by a randomized run.
// ============================================================================
module tb_game_state_tracker;

   localparam int PHP = 3;
   localparam int EHP = 3;
`ifdef GAME_STATE_TIE_EN
   localparam int TIE_CODE = 3;
`else
   localparam int TIE_CODE = 2;
`endif

   logic clk;
   logic rst;
   logic vblnk;
   logic start;
   logic back;
   logic phit;
   logic ehit;

   logic [1:0] ge  [2];
   logic       ga  [2];
   logic [3:0] php [2];
   logic [3:0] ehp [2];

   int n_cmp;
   int n_bad;

   game_state_tracker #(
      .PLAYER_HP    (PHP),
      .ENEMY_HP     (EHP),
      .HIT_COOLDOWN (0)
   ) u_dut0 (
      .clk          (clk),
      .rst          (rst),
      .vblnk_in     (vblnk),
      .start        (start),
      .back_to_MENU (back),
      .player_hit   (phit),
      .enemy_hit    (ehit),
      .game_end     (ge[0]),
      .game_active  (ga[0]),
      .player_hp    (php[0]),
      .enemy_hp     (ehp[0])
   );

   game_state_tracker #(
      .PLAYER_HP    (PHP),
      .ENEMY_HP     (EHP),
      .HIT_COOLDOWN (2)
   ) u_dut2 (
      .clk          (clk),
      .rst          (rst),
      .vblnk_in     (vblnk),
      .start        (start),
      .back_to_MENU (back),
      .player_hit   (phit),
      .enemy_hit    (ehit),
      .game_end     (ge[1]),
      .game_active  (ga[1]),
      .player_hp    (php[1]),
      .enemy_hp     (ehp[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // Reference model. Cooldown is expressed as "frames since the last
   // applied hit": a pending hit lands only if more than COOL frames have
   // passed. Match phase: 0 idle, 1 playing, 2 showing a result.
   // -------------------------------------------------------------------------
   int cool    [2] = '{0, 2};
   int m_phase [2];
   int m_end   [2];
   int m_hp    [2][2];
   int m_frame [2];
   int m_last  [2][2];
   int m_seen  [2][2];
   bit m_vb    [2];

   task automatic model_reset(input int k);
      m_phase[k] = 0;
      m_end[k]   = 0;
      m_frame[k] = 0;
      m_vb[k]    = 1'b0;
      for (int s = 0; s < 2; s++) begin
         m_hp[k][s]   = 0;
         m_last[k][s] = -1000;
         m_seen[k][s] = 0;
      end
   endtask

   task automatic model_step(input int k);
      bit tick;
      tick    = vblnk && !m_vb[k];
      m_vb[k] = vblnk;
      if (rst) begin
         model_reset(k);
         return;
      end
      if (m_phase[k] == 0) begin
         if (start) begin
            m_phase[k] = 1;
            m_hp[k][0] = PHP;
            m_hp[k][1] = EHP;
            m_frame[k] = 0;
            for (int s = 0; s < 2; s++) begin
               m_last[k][s] = -1000;
               m_seen[k][s] = 0;
            end
         end
      end else if (m_phase[k] == 1) begin
         m_seen[k][0] += int'(phit);
         m_seen[k][1] += int'(ehit);
         if (tick) begin
            m_frame[k]++;
            for (int s = 0; s < 2; s++) begin
               if (m_seen[k][s] > 0 && (m_frame[k] - m_last[k][s]) > cool[k]) begin
                  if (m_hp[k][s] > 0) m_hp[k][s]--;
                  m_last[k][s] = m_frame[k];
               end
               m_seen[k][s] = 0;
            end
            if (m_hp[k][0] == 0) begin
               m_phase[k] = 2;
               m_end[k]   = (m_hp[k][1] == 0) ? TIE_CODE : 2;
            end else if (m_hp[k][1] == 0) begin
               m_phase[k] = 2;
               m_end[k]   = 1;
            end
         end
      end else begin
         if (back) begin
            m_phase[k] = 0;
            m_end[k]   = 0;
            m_hp[k][0] = 0;
            m_hp[k][1] = 0;
         end
      end
   endtask

   // -------------------------------------------------------------------------
   // Comparison helpers
   // -------------------------------------------------------------------------
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("model.u%0d.game_end", k),    int'(ge[k]),  m_end[k]);
         chk($sformatf("model.u%0d.game_active", k), int'(ga[k]),  (m_phase[k] == 1) ? 1 : 0);
         chk($sformatf("model.u%0d.player_hp", k),   int'(php[k]), m_hp[k][0]);
         chk($sformatf("model.u%0d.enemy_hp", k),    int'(ehp[k]), m_hp[k][1]);
      end
   endtask

   // Apply inputs for one cycle (called at a negedge), step the model on the
   // posedge, check on the following negedge.
   task automatic drive(input logic vb, input logic st, input logic bk,
                        input logic p, input logic e);
      vblnk = vb;
      start = st;
      back  = bk;
      phit  = p;
      ehit  = e;
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_model();
   endtask

   // One frame: six active-video cycles (hits in the first nh of them unless
   // the hit is placed on the tick), then the tick cycle and one more vblank.
   task automatic frame(input int nh, input bit p, input bit e, input bit on_tick);
      for (int i = 0; i < 6; i++)
         drive(1'b0, 1'b0, 1'b0, p && !on_tick && (i < nh), e && !on_tick && (i < nh));
      drive(1'b1, 1'b0, 1'b0, p && on_tick, e && on_tick);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("frame: nh=%0d ph=%0d eh=%0d on_tick=%0d -> u0 hp %0d/%0d end %0d | u2 hp %0d/%0d end %0d",
               nh, p, e, on_tick, php[0], ehp[0], ge[0], php[1], ehp[1], ge[1]);
   endtask

   task automatic sync_reset_and_start();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      $display("reset + start -> u0 hp %0d/%0d, u2 hp %0d/%0d", php[0], ehp[0], php[1], ehp[1]);
   endtask

   // -------------------------------------------------------------------------
   // Directed table for u_dut0 (no cooldown), starting from a fresh 3/3 match
   // -------------------------------------------------------------------------
   typedef struct {
      int nh;
      bit ph;
      bit eh;
      bit on_tick;
      int exp_php;
      int exp_ehp;
      int exp_end;
      int exp_act;
   } vec_t;

   vec_t tbl [4];

   initial begin
      n_cmp = 0;
      n_bad = 0;

      tbl[0] = '{1, 1'b0, 1'b1, 1'b0, 3, 2, 0, 1};
      tbl[1] = '{1, 1'b0, 1'b1, 1'b0, 3, 1, 0, 1};
      tbl[2] = '{1, 1'b0, 1'b1, 1'b0, 3, 0, 1, 0};
      tbl[3] = '{2, 1'b1, 1'b1, 1'b0, 3, 0, 1, 0};   // hits in WIN are ignored

      vblnk = 1'b0;
      start = 1'b0;
      back  = 1'b0;
      phit  = 1'b0;
      ehit  = 1'b0;
      rst   = 1'b1;
      model_reset(0);
      model_reset(1);

      // ---- reset state ----------------------------------------------------
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("reset.game_end",    int'(ge[k]),  0);
         chk("reset.game_active", int'(ga[k]),  0);
         chk("reset.player_hp",   int'(php[k]), 0);
         chk("reset.enemy_hp",    int'(ehp[k]), 0);
      end
      rst = 1'b0;
      $display("reset released");

      // ---- start, then the directed win sequence --------------------------
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("start.u0.active",    int'(ga[0]),  1);
      chk("start.u0.player_hp", int'(php[0]), PHP);
      chk("start.u0.enemy_hp",  int'(ehp[0]), EHP);
      $display("start -> u0 active %0d hp %0d/%0d", ga[0], php[0], ehp[0]);

      for (int i = 0; i < 4; i++) begin
         frame(tbl[i].nh, tbl[i].ph, tbl[i].eh, tbl[i].on_tick);
         chk($sformatf("tbl[%0d].player_hp", i),   int'(php[0]), tbl[i].exp_php);
         chk($sformatf("tbl[%0d].enemy_hp", i),    int'(ehp[0]), tbl[i].exp_ehp);
         chk($sformatf("tbl[%0d].game_end", i),    int'(ge[0]),  tbl[i].exp_end);
         chk($sformatf("tbl[%0d].game_active", i), int'(ga[0]),  tbl[i].exp_act);
      end

      // ---- WIN ignores start, leaves on back_to_MENU ----------------------
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("win.start_ignored.end", int'(ge[0]), 1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // both pulses: only back acts
      chk("win.back.end",    int'(ge[0]),  0);
      chk("win.back.php",    int'(php[0]), 0);
      chk("win.back.ehp",    int'(ehp[0]), 0);
      chk("win.back.active", int'(ga[0]),  0);
      $display("back_to_MENU -> u0 end %0d hp %0d/%0d", ge[0], php[0], ehp[0]);
      frame(1, 1'b1, 1'b1, 1'b0);             // hits in IDLE
      chk("idle.hits.php", int'(php[0]), 0);
      chk("idle.hits.ehp", int'(ehp[0]), 0);

      // ---- collapse and cooldown ------------------------------------------
      sync_reset_and_start();
      frame(5, 1'b1, 1'b0, 1'b0);
      chk("collapse.u0.php", int'(php[0]), 2);
      chk("collapse.u2.php", int'(php[1]), 2);
      frame(1, 1'b1, 1'b0, 1'b0);
      chk("cool1.u2.php", int'(php[1]), 2);
      frame(1, 1'b1, 1'b0, 1'b0);
      chk("cool2.u2.php", int'(php[1]), 2);
      chk("cool2.u0.end", int'(ge[0]),  2);
      frame(1, 1'b1, 1'b0, 1'b0);
      chk("cool3.u2.php", int'(php[1]), 1);

      // ---- simultaneous zero ----------------------------------------------
      sync_reset_and_start();
      repeat (3) frame(1, 1'b1, 1'b1, 1'b0);
      chk("tie.u0.end",    int'(ge[0]),  TIE_CODE);
      chk("tie.u0.active", int'(ga[0]),  0);
      chk("tie.u2.php",    int'(php[1]), 2);

      // ---- hit placed on the tick cycle ------------------------------------
      sync_reset_and_start();
      frame(1, 1'b0, 1'b1, 1'b1);
      chk("ontick.u0.ehp", int'(ehp[0]), 2);
      chk("ontick.u2.ehp", int'(ehp[1]), 2);
      frame(0, 1'b0, 1'b0, 1'b0);
      chk("ontick.next.u0.ehp", int'(ehp[0]), 2);

      // ---- asynchronous reset mid-match with a pending hit ----------------
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);   // pending on both sides, u2 cooling
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("async.game_end",    int'(ge[k]),  0);
         chk("async.game_active", int'(ga[k]),  0);
         chk("async.player_hp",   int'(php[k]), 0);
         chk("async.enemy_hp",    int'(ehp[k]), 0);
      end
      model_reset(0);
      model_reset(1);
      $display("async reset mid-match -> outputs %0d/%0d/%0d/%0d", ge[0], ga[0], php[0], ehp[0]);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      frame(0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("after_async.php", int'(php[k]), PHP);
         chk("after_async.ehp", int'(ehp[k]), EHP);
      end
      frame(1, 1'b0, 1'b1, 1'b0);
      chk("after_async.hit.u2.ehp", int'(ehp[1]), 2);

      // ---- randomized run against the model -------------------------------
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      begin
         logic vb_r;
         vb_r = 1'b0;
         for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 4) == 0) vb_r = ~vb_r;
            rst = ($urandom_range(0, 500) == 0);
            drive(vb_r,
                  $urandom_range(0, 25) == 0,
                  $urandom_range(0, 25) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 6) == 0);
            if (ge[0] != 2'd0 && m_phase[0] == 2 && $urandom_range(0, 49) == 0)
               $display("random c=%0d: u0 end %0d hp %0d/%0d | u2 end %0d hp %0d/%0d",
                        c, ge[0], php[0], ehp[0], ge[1], php[1], ehp[1]);
         end
         rst = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/game_state_tracker.md
Name: game_state_tracker

Overview:
- Tracks player and enemy hit points during a match and owns the round state: idle, playing, won, lost.
- Produces the 2-bit game_end code consumed by the end-screen overlay stage that sits directly downstream.
- Applies hits only at frame boundaries (rising edge of vblnk), so game_end and HP never change mid-frame.
- Returns to idle when the end screen pulses back_to_MENU.

Parameters:
- PLAYER_HP, 3, starting player hit points; range 1..15.
- ENEMY_HP, 3, starting enemy hit points; range 1..15.
- HIT_COOLDOWN, 30, frames of invulnerability after an applied hit, per side; range 0..255.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- vblnk_in  in  1  vertical blank from the timing chain; its rising edge is the frame tick
- start  in  1  one-cycle pulse from the menu; begins a match
- back_to_MENU  in  1  one-cycle pulse from the end-screen stage; leaves WIN/LOSE
- player_hit  in  1  one-cycle pulse: a projectile hit the player tank
- enemy_hit  in  1  one-cycle pulse: a projectile hit the enemy tank
- game_end  out  2  0 = none, 1 = win, 2 = lose (3 reserved, see optional feature)
- game_active  out  1  high in PLAY
- player_hp  out  4  current player HP
- enemy_hp  out  4  current enemy HP

Behaviour:
- Reset (async, any time, including mid-match) forces the following on the same edge:
  - state = IDLE, game_end = 0, game_active = 0
  - player_hp = 0, enemy_hp = 0
  - cooldown counters = 0, pending flags = 0, vblnk delay register = 0
- Frame tick: asserted in the cycle where vblnk_in = 1 and the registered vblnk_in = 0. Exactly one cycle per frame.
- Pending flags, one per side:
  - Set by the hit pulse.
  - Sticky until the next frame tick.
  - A hit pulse in the tick cycle itself counts toward that tick.
  - Multiple hits within one frame collapse to one hit.
- At each frame tick in PLAY, per side:
  - If cooldown = 0 and the pending flag is set: HP decrements by 1 (saturating at 0) and cooldown loads HIT_COOLDOWN.
  - Else if cooldown != 0: cooldown decrements by 1 and any pending hit is discarded.
  - Pending flags always clear at the tick.
- Outputs are all registered and change on the clock edge following the tick cycle (latency 1 cycle from tick).
- State machine:
  - IDLE: start -> PLAY. On that transition, load player_hp = PLAYER_HP and enemy_hp = ENEMY_HP, clear cooldowns and pending flags. back_to_MENU is ignored.
  - PLAY: state is evaluated on the same edge as the HP update.
    - If the post-update player_hp = 0 -> LOSE (game_end = 2).
    - Else if the post-update enemy_hp = 0 -> WIN (game_end = 1).
    - Simultaneous zero -> LOSE (player priority).
    - start and back_to_MENU are ignored.
  - WIN / LOSE: HP frozen, hits ignored, pending flags held clear. back_to_MENU -> IDLE, game_end = 0, HP = 0. start is ignored.
- game_end is held constant for the whole time the machine is in WIN/LOSE. The downstream stage's long timeout relies on this.
- start and back_to_MENU arriving in the same cycle: only the one legal in the current state acts.
- HIT_COOLDOWN = 0: every frame with a pending hit decrements HP.

Optional Feature:
- Macro: GAME_STATE_TIE_EN.
- Defined: simultaneous zero HP in one tick -> state DRAW, game_end = 3. DRAW behaves like WIN/LOSE: frozen until back_to_MENU -> IDLE. The downstream overlay shows no text for code 3.
- Undefined: no DRAW state; simultaneous zero resolves to LOSE (game_end = 2).

Test Plan:
- Reset then start; 3 enemy_hit pulses in separate frames with HIT_COOLDOWN = 0 -> enemy_hp steps 3, 2, 1, 0. game_end = 1 and game_active = 0 one cycle after the third tick. player_hp = 3.
- 5 player_hit pulses within one frame -> player_hp drops by exactly 1 at the tick. With HIT_COOLDOWN = 2, hits in the next 2 frames are discarded and a hit in the 3rd frame decrements HP.
- Both HP = 1; player_hit and enemy_hit in the same frame -> game_end = 2 (macro undefined) or 3 (GAME_STATE_TIE_EN defined).
- In WIN: pulse start, player_hit and enemy_hit -> no change. Pulse back_to_MENU -> next cycle game_end = 0, HP = 0, state IDLE. Hits in IDLE -> ignored.
- Hit pulse in the exact tick cycle -> applied at that tick, not the next frame.
- Assert rst mid-PLAY with a pending hit and cooldown = 17 -> all outputs 0 immediately (asynchronously). After release, start reloads HP = 3/3 with no stale hit applied.
